// File: rtl/cn_aes_keyed_round.sv
// Single-lane CryptoNight AES engine: expands a 256-bit key into ten round keys
// and applies ten plain aesenc rounds to one 128-bit block.
module cn_aes_keyed_round (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_lo,
    input  logic [127:0] key_hi,
    input  logic         start_round,
    input  logic [127:0] xin,
    output logic         keygen_done,
    output logic [127:0] k0,
    output logic [127:0] k1,
    output logic [127:0] k2,
    output logic [127:0] k3,
    output logic [127:0] k4,
    output logic [127:0] k5,
    output logic [127:0] k6,
    output logic [127:0] k7,
    output logic [127:0] k8,
    output logic [127:0] k9,
    output logic         round_done,
    output logic [127:0] xout
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Running XOR of the previous key of the same parity, seeded with t.
    function automatic logic [127:0] expand_key(input logic [127:0] prev, input logic [31:0] t);
        logic [31:0] w0, w1, w2, w3;
        w0 = prev[31:0]   ^ t;
        w1 = prev[63:32]  ^ w0;
        w2 = prev[95:64]  ^ w1;
        w3 = prev[127:96] ^ w2;
        return {w3, w2, w1, w0};
    endfunction

    // Byte 4c+r is row r of column c; bytes live little-endian in the vector.
    function automatic logic [127:0] aes_enc(input logic [127:0] s, input logic [127:0] k);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [127:0] mc;
        logic [7:0]   a0, a1, a2, a3;
        for (int i = 0; i < 16; i++) begin
            sb[i] = sub_byte(s[8*i +: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sb[4*((c+r)%4)+r];
            end
        end
        mc = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            mc[32*c +: 8]    = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mc[32*c+8 +: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mc[32*c+16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mc[32*c+24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return mc ^ k;
    endfunction

    typedef enum logic [2:0] {
        KG_LOAD,
        KG_EXP1,
        KG_EXP2,
        KG_EXP3,
        KG_EXP4,
        KG_DONE
    } kg_state_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_RUN,
        RD_DONE
    } rd_state_t;

    kg_state_t    kg_state;
    rd_state_t    rd_state;
    logic [127:0] rk [10];
    logic [127:0] wa, wb;
    logic [7:0]   rcon;
    logic [31:0]  t_even;
    logic [127:0] next_even, next_odd;
    logic [127:0] st;
    logic [3:0]   cnt;
    logic [127:0] rin, rkey, round_out;

    // wa/wb always hold the two most recent keys (even, odd) of the schedule.
    always_comb begin
        rcon = 8'h00;
        case (kg_state)
            KG_EXP1: rcon = 8'h01;
            KG_EXP2: rcon = 8'h02;
            KG_EXP3: rcon = 8'h04;
            KG_EXP4: rcon = 8'h08;
            default: rcon = 8'h00;
        endcase
        t_even    = sub_word(wb[127:96]);
        t_even    = {t_even[7:0], t_even[31:8]} ^ {24'h0, rcon};
        next_even = expand_key(wa, t_even);
        next_odd  = expand_key(wb, sub_word(next_even[127:96]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kg_state    <= KG_LOAD;
            keygen_done <= 1'b0;
            wa          <= '0;
            wb          <= '0;
            for (int i = 0; i < 10; i++) begin
                rk[i] <= '0;
            end
        end else begin
            case (kg_state)
                KG_LOAD: begin
                    wa       <= key_lo;
                    wb       <= key_hi;
                    rk[0]    <= key_lo;
                    rk[1]    <= key_hi;
                    kg_state <= KG_EXP1;
                end
                KG_EXP1: begin
                    wa       <= next_even;
                    wb       <= next_odd;
                    rk[2]    <= next_even;
                    rk[3]    <= next_odd;
                    kg_state <= KG_EXP2;
                end
                KG_EXP2: begin
                    wa       <= next_even;
                    wb       <= next_odd;
                    rk[4]    <= next_even;
                    rk[5]    <= next_odd;
                    kg_state <= KG_EXP3;
                end
                KG_EXP3: begin
                    wa       <= next_even;
                    wb       <= next_odd;
                    rk[6]    <= next_even;
                    rk[7]    <= next_odd;
                    kg_state <= KG_EXP4;
                end
                KG_EXP4: begin
                    wa          <= next_even;
                    wb          <= next_odd;
                    rk[8]       <= next_even;
                    rk[9]       <= next_odd;
                    keygen_done <= 1'b1;
                    kg_state    <= KG_DONE;
                end
                default: kg_state <= KG_DONE;
            endcase
        end
    end

    // One shared round datapath: IDLE feeds xin with k0, RUN feeds state with k[cnt].
    always_comb begin
        rkey = rk[0];
        if (rd_state != RD_IDLE) begin
            for (int i = 0; i < 10; i++) begin
                if (cnt == i[3:0]) rkey = rk[i];
            end
        end
        rin       = (rd_state == RD_IDLE) ? xin : st;
        round_out = aes_enc(rin, rkey);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state   <= RD_IDLE;
            st         <= '0;
            cnt        <= '0;
            round_done <= 1'b0;
            xout       <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (start_round && keygen_done) begin
                        st       <= round_out;
                        cnt      <= 4'd1;
                        rd_state <= RD_RUN;
                    end
                end
                RD_RUN: begin
                    st <= round_out;
                    if (cnt == 4'd9) begin
                        xout       <= round_out;
                        round_done <= 1'b1;
                        rd_state   <= RD_DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RD_DONE: begin
                    if (!start_round) begin
                        round_done <= 1'b0;
                        rd_state   <= RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    assign k0 = rk[0];
    assign k1 = rk[1];
    assign k2 = rk[2];
    assign k3 = rk[3];
    assign k4 = rk[4];
    assign k5 = rk[5];
    assign k6 = rk[6];
    assign k7 = rk[7];
    assign k8 = rk[8];
    assign k9 = rk[9];

endmodule

// File: tb/tb_cn_aes_keyed_round.sv
// Bench for cn_aes_keyed_round: GF(2^8)-derived AES model, word-wise AES-256
// schedule, and a per-cycle compare against expected timing and values.
module tb_cn_aes_keyed_round;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] key_lo = '0;
    logic [127:0] key_hi = '0;
    logic         start_round = 1'b0;
    logic [127:0] xin = '0;
    logic         keygen_done, round_done;
    logic [127:0] k0, k1, k2, k3, k4, k5, k6, k7, k8, k9, xout;
    logic [127:0] dut_k [10];

    always #5 clk = ~clk;

    cn_aes_keyed_round dut (
        .clk(clk), .rst(rst), .key_lo(key_lo), .key_hi(key_hi),
        .start_round(start_round), .xin(xin), .keygen_done(keygen_done),
        .k0(k0), .k1(k1), .k2(k2), .k3(k3), .k4(k4), .k5(k5), .k6(k6),
        .k7(k7), .k8(k8), .k9(k9), .round_done(round_done), .xout(xout)
    );

    assign dut_k[0] = k0;
    assign dut_k[1] = k1;
    assign dut_k[2] = k2;
    assign dut_k[3] = k3;
    assign dut_k[4] = k4;
    assign dut_k[5] = k5;
    assign dut_k[6] = k6;
    assign dut_k[7] = k7;
    assign dut_k[8] = k8;
    assign dut_k[9] = k9;

    int           checks = 0;
    int           failures = 0;
    bit           cmp_en = 1'b0;
    logic [7:0]   m_sbox [256];
    logic [127:0] fips_lit [10];
    logic [127:0] cur_lo, cur_hi;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = (v << n) | (v >> (8 - n));
        return r;
    endfunction

    function automatic logic [31:0] sub_word_m(input logic [31:0] w);
        return {m_sbox[w[31:24]], m_sbox[w[23:16]], m_sbox[w[15:8]], m_sbox[w[7:0]]};
    endfunction

    function automatic logic [7:0] mc_coef(input int r, input int c);
        int d;
        d = (c - r + 4) % 4;
        return (d == 0) ? 8'h02 : ((d == 1) ? 8'h03 : 8'h01);
    endfunction

    function automatic logic [127:0] aesenc_m(input logic [127:0] s, input logic [127:0] k);
        logic [7:0]   m [4][4];
        logic [7:0]   n [4][4];
        logic [7:0]   acc;
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = m_sbox[s[8*(r+4*c) +: 8]];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                n[r][c] = m[r][(c+r)%4];
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                acc = '0;
                for (int q = 0; q < 4; q++) acc = acc ^ gmul(mc_coef(r, q), n[q][c]);
                o[8*(r+4*c) +: 8] = acc;
            end
        end
        return o ^ k;
    endfunction

    // AES-256 word recurrence (Nk = 8); round key n is words 4n..4n+3.
    function automatic logic [1279:0] expand_m(input logic [127:0] lo, input logic [127:0] hi);
        logic [31:0]   w [40];
        logic [31:0]   t;
        logic [1279:0] ks;
        for (int i = 0; i < 4; i++) begin
            w[i]   = lo[32*i +: 32];
            w[4+i] = hi[32*i +: 32];
        end
        for (int i = 8; i < 40; i++) begin
            t = w[i-1];
            if (i % 8 == 0) t = sub_word_m({t[7:0], t[31:8]}) ^ (32'h1 << (i/8 - 1));
            else if (i % 8 == 4) t = sub_word_m(t);
            w[i] = w[i-8] ^ t;
        end
        for (int i = 0; i < 40; i++) ks[32*i +: 32] = w[i];
        return ks;
    endfunction

    function automatic logic [127:0] aes10_m(input logic [127:0] x, input logic [1279:0] ks);
        logic [127:0] s;
        s = x;
        for (int r = 0; r < 10; r++) s = aesenc_m(s, ks[128*r +: 128]);
        return s;
    endfunction

    // FIPS-197 writes blocks as byte strings, byte 0 first.
    function automatic logic [127:0] le(input logic [127:0] v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = v[8*(15-i) +: 8];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- expected-behaviour tracker ----------------
    logic [127:0]  exp_q [$];
    int            m_kg_cnt = 0;
    logic [1279:0] m_keys = '0;
    int            m_phase = 0;
    int            m_left = 0;
    logic          m_done = 1'b0;
    logic [127:0]  m_xout = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_kg_cnt <= 0;
            m_keys   <= '0;
            m_phase  <= 0;
            m_left   <= 0;
            m_done   <= 1'b0;
            m_xout   <= '0;
            exp_q.delete();
        end else begin
            if (m_kg_cnt < 5) m_kg_cnt <= m_kg_cnt + 1;
            if (m_kg_cnt == 0) m_keys <= expand_m(key_lo, key_hi);
            case (m_phase)
                0: if (start_round && m_kg_cnt == 5) begin
                    exp_q.push_back(aes10_m(xin, m_keys));
                    m_left  <= 9;
                    m_phase <= 1;
                end
                1: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_phase <= 2;
                        m_done  <= 1'b1;
                        m_xout  <= exp_q.pop_front();
                    end
                end
                default: if (!start_round) begin
                    m_phase <= 0;
                    m_done  <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- checking ----------------
    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check1("cyc_keygen_done", keygen_done, m_kg_cnt == 5);
            check1("cyc_round_done", round_done, m_done);
            check128("cyc_xout", xout, m_xout);
            if (m_kg_cnt == 0 || m_kg_cnt == 5) begin
                for (int i = 0; i < 10; i++)
                    check128($sformatf("cyc_k%0d", i), dut_k[i], m_keys[128*i +: 128]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset(input logic [127:0] lo, input logic [127:0] hi);
        @(negedge clk);
        rst = 1'b1;
        start_round = 1'b0;
        key_lo = lo;
        key_hi = hi;
        cur_lo = lo;
        cur_hi = hi;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_kg(output int n);
        n = 0;
        while (!keygen_done && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    // mode 0: plain, 1: disturb xin during RUN, 2: drop start during RUN
    task automatic run_block(input logic [127:0] x, input int hold, input int mode);
        logic [127:0] exp;
        int n;
        exp = aes10_m(x, expand_m(cur_lo, cur_hi));
        xin = x;
        start_round = 1'b1;
        n = 0;
        while (!round_done && n < 40) begin
            @(negedge clk);
            n++;
            if (mode == 1 && n == 2) xin = rand128();
            if (mode == 2 && n == 3) start_round = 1'b0;
        end
        check_int("round_latency", n, 10);
        check128("round_result", xout, exp);
        if (mode != 2) begin
            repeat (hold) @(negedge clk);
            check1("hold_round_done", round_done, 1'b1);
            check128("hold_xout", xout, exp);
            start_round = 1'b0;
        end
        @(negedge clk);
        check1("drop_round_done", round_done, 1'b0);
        check128("kept_xout", xout, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic [1279:0] fk;
        logic [127:0] fips_lo, fips_hi, x;
        logic [7:0] inv, xb;

        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            xb = v[7:0];
            for (int y = 1; y < 256; y++)
                if (gmul(xb, y[7:0]) == 8'h01) inv = y[7:0];
            m_sbox[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end

        fips_lit[0] = 128'h000102030405060708090a0b0c0d0e0f;
        fips_lit[1] = 128'h101112131415161718191a1b1c1d1e1f;
        fips_lit[2] = 128'ha573c29fa176c498a97fce93a572c09c;
        fips_lit[3] = 128'h1651a8cd0244beda1a5da4c10640bade;
        fips_lit[4] = 128'hae87dff00ff11b68a68ed5fb03fc1567;
        fips_lit[5] = 128'h6de1f1486fa54f9275f8eb5373b8518d;
        fips_lit[6] = 128'hc656827fc9a799176f294cec6cd5598b;
        fips_lit[7] = 128'h3de23a75524775e727bf9eb45407cf39;
        fips_lit[8] = 128'h0bdc905fc27b0948ad5245a4c1871c2f;
        fips_lit[9] = 128'h45f5a66017b2d387300d4d33640a820a;
        fips_lo = le(fips_lit[0]);
        fips_hi = le(fips_lit[1]);

        // Pin the model itself to known values.
        check128("model_round_zero", aesenc_m('0, '0), {16{8'h63}});
        check128("model_fips_round",
                 aesenc_m(le(128'h193de3bea0f4e22b9ac68d2ae9f84808), le(128'ha0fafe1788542cb123a339392a6c7605)),
                 le(128'ha49c7ff2689f352b6b5bea43026a5049));
        fk = expand_m(fips_lo, fips_hi);
        for (int i = 2; i < 10; i++) check128($sformatf("model_fips_k%0d", i), fk[128*i +: 128], le(fips_lit[i]));

        @(posedge clk);
        #1 cmp_en = 1'b1;
        check1("reset_keygen_done", keygen_done, 1'b0);
        check1("reset_round_done", round_done, 1'b0);
        check128("reset_xout", xout, '0);
        check128("reset_k9", k9, '0);

        // Zero key: literals, latency, hold.
        do_reset('0, '0);
        wait_kg(n);
        check_int("keygen_latency_zero", n, 5);
        check128("zero_k2", k2, 128'h63636362636363626363636263636362);
        check128("zero_k3", k3, 128'hfbfbfbaafbfbfbaafbfbfbaafbfbfbaa);
        run_block('0, 3, 0);
        run_block(rand128(), $urandom_range(0, 4), 1);
        run_block(rand128(), 0, 2);

        // FIPS key with start asserted before keys are ready.
        do_reset(fips_lo, fips_hi);
        x = rand128();
        xin = x;
        start_round = 1'b1;
        n = 0;
        while (!round_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_int("early_start_latency", n, 15);
        check128("early_start_result", xout, aes10_m(x, fk));
        for (int i = 0; i < 10; i++) check128($sformatf("fips_k%0d", i), dut_k[i], le(fips_lit[i]));
        start_round = 1'b0;
        @(negedge clk);
        run_block(rand128(), $urandom_range(1, 3), 0);

        // Reset in the middle of a run, with cnt at 5.
        xin = rand128();
        start_round = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        start_round = 1'b0;
        @(negedge clk);
        check1("midrst_round_done", round_done, 1'b0);
        check128("midrst_xout", xout, '0);
        check1("midrst_keygen_done", keygen_done, 1'b0);
        rst = 1'b0;
        wait_kg(n);
        check_int("keygen_latency_rerun", n, 5);
        for (int i = 2; i < 10; i++) check128($sformatf("rerun_k%0d", i), dut_k[i], le(fips_lit[i]));
        run_block(rand128(), 1, 0);

        // Random keys and blocks.
        for (int t = 0; t < 4; t++) begin
            do_reset(rand128(), rand128());
            wait_kg(n);
            check_int("keygen_latency_rand", n, 5);
            for (int b = 0; b < 3; b++) begin
                run_block(rand128(), $urandom_range(0, 3), $urandom_range(0, 2));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
